// File: rtl/button_conditioner.sv
// button_conditioner: per-button 2-FF synchronizer, debouncer and one-cycle press pulse for the RTC navigation keys.
// Define AUTOREPEAT_EN to add the hold-to-repeat FSM (DELAY/REPEAT states with their counters).
module button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int DEB_CYCLES   = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_pulse
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("button_conditioner: DEB_CYCLES must be >= 2 and repeat periods >= 1");
    end

    logic [N_BTN-1:0]            sync1_q, sync2_q;
    logic [N_BTN-1:0]            level_q, level_d;
    logic [N_BTN-1:0]            rise_d;
    logic [N_BTN-1:0]            pulse_q, pulse_d;
    logic                        any_q;
    logic [N_BTN-1:0][DEB_W-1:0] deb_q, deb_d;

    // A new level is taken only after DEB_CYCLES consecutive samples disagree with the current one.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        deb_d   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            deb_q   <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            deb_q   <= deb_d;
            pulse_q <= pulse_d;
            any_q   <= |pulse_d;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;

    state_t           state_q [N_BTN];
    logic [REP_W-1:0] rep_q   [N_BTN];
    logic             freeze;

    // Holding two or more buttons parks every repeat timer where it is.
    assign freeze = ($countones(level_q) > 1);

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (level_d[i]) begin
                case (state_q[i])
                    ST_IDLE:   pulse_d[i] = rise_d[i];
                    ST_DELAY:  pulse_d[i] = !freeze && (rep_q[i] == DELAY_LAST);
                    ST_REPEAT: pulse_d[i] = !freeze && (rep_q[i] == RATE_LAST);
                    default:   pulse_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ST_IDLE;
                rep_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!level_d[i]) begin
                    state_q[i] <= ST_IDLE;
                    rep_q[i]   <= '0;
                end else begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (rise_d[i]) begin
                                state_q[i] <= ST_DELAY;
                                rep_q[i]   <= '0;
                            end
                        end
                        ST_DELAY: begin
                            if (!freeze) begin
                                if (rep_q[i] == DELAY_LAST) begin
                                    state_q[i] <= ST_REPEAT;
                                    rep_q[i]   <= '0;
                                end else begin
                                    rep_q[i] <= rep_q[i] + 1'b1;
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (!freeze) begin
                                if (rep_q[i] == RATE_LAST) begin
                                    rep_q[i] <= '0;
                                end else begin
                                    rep_q[i] <= rep_q[i] + 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q[i] <= ST_IDLE;
                            rep_q[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    assign pulse_d = rise_d;
`endif

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign any_pulse = any_q;

endmodule
